// File: rtl/astropix_spi_responder_emu.sv
// AstroPix SPI responder emulator: buffers AXI-Stream frame bytes, shifts them out on a
// dual-lane MISO as the host clocks SPI, and captures MOSI bytes.
module astropix_spi_responder_emu #(
  parameter int unsigned DEPTH          = 32,
  parameter logic [7:0]  IDLE_BYTE      = 8'hBC,
  parameter bit          MOSI_MSB_FIRST = 1'b0
) (
  input  logic       clk_core,
  input  logic       clk_core_resn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       spi_clk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic [1:0] spi_miso,
  output logic       interruptn,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       stat_tx_truncated,
  output logic [7:0] frames_pending
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  logic [8:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        tready_q, tready_d;
  logic [7:0]  frames_q, frames_d;
  logic        intn_q, intn_d;
  logic [2:0]  sclk_sync_q, csn_sync_q;
  logic [1:0]  mosi_sync_q;
  state_t      state_q, state_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  miso_q, miso_d;
  logic        trunc_q, trunc_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;

  logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic       fifo_empty, wr_en, pop_en, load_now;
  logic       tlast_in, tlast_out;
  logic [8:0] fifo_head;
  logic [7:0] load_byte;

  // Bit 0 is the first synchronizer stage, bit 2 the edge-detect history stage.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
  assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];
  assign wr_en      = s_axis_tvalid & tready_q;
  assign load_byte  = fifo_empty ? IDLE_BYTE : fifo_head[7:0];
  assign pop_en     = load_now & ~fifo_empty;
  assign tlast_in   = wr_en & s_axis_tlast;
  assign tlast_out  = pop_en & fifo_head[8];

  always_ff @(posedge clk_core) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
    tready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    frames_d = frames_q;
    if (tlast_in && !tlast_out) begin
      if (frames_q != 8'hFF) frames_d = frames_q + 8'd1;
    end else if (tlast_out && !tlast_in) begin
      if (frames_q != 8'h00) frames_d = frames_q - 8'd1;
    end
    intn_d = (frames_q == 8'h00);
  end

  // The 4th falling edge of a byte reloads instead of shifting, so MISO never stalls.
  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    lane_d   = lane_q;
    miso_d   = miso_q;
    trunc_d  = 1'b0;
    load_now = 1'b0;
    if (csn_rise) begin
      state_d = ST_IDLE;
      lane_d  = 2'd0;
      miso_d  = 2'b00;
      trunc_d = (state_q == ST_SHIFT) && (lane_q != 2'd0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csn_fall) state_d = ST_LOAD;
        end
        ST_LOAD: load_now = 1'b1;
        ST_SHIFT: begin
          if (sclk_fall) begin
            if (lane_q == 2'd3) begin
              load_now = 1'b1;
            end else begin
              tx_sr_d = {2'b00, tx_sr_q[7:2]};
              lane_d  = lane_q + 2'd1;
              miso_d  = tx_sr_q[3:2];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (load_now) begin
        state_d = ST_SHIFT;
        tx_sr_d = load_byte;
        lane_d  = 2'd0;
        miso_d  = load_byte[1:0];
      end
    end
  end

  always_comb begin
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    if (csn_rise) begin
      rx_cnt_d = 3'd0;
    end else if (!csn_sync_q[1] && sclk_rise) begin
      rx_sr_d  = MOSI_MSB_FIRST ? {rx_sr_q[6:0], mosi_sync_q[1]}
                                : {mosi_sync_q[1], rx_sr_q[7:1]};
      rx_cnt_d = rx_cnt_q + 3'd1;
      if (rx_cnt_q == 3'd7) begin
        rx_byte_d  = rx_sr_d;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_core or negedge clk_core_resn) begin
    if (!clk_core_resn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tready_q    <= 1'b0;
      frames_q    <= 8'h00;
      intn_q      <= 1'b1;
      sclk_sync_q <= 3'b000;
      csn_sync_q  <= 3'b111;
      mosi_sync_q <= 2'b00;
      state_q     <= ST_IDLE;
      tx_sr_q     <= 8'h00;
      lane_q      <= 2'd0;
      miso_q      <= 2'b00;
      trunc_q     <= 1'b0;
      rx_sr_q     <= 8'h00;
      rx_cnt_q    <= 3'd0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tready_q    <= tready_d;
      frames_q    <= frames_d;
      intn_q      <= intn_d;
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      csn_sync_q  <= {csn_sync_q[1:0], spi_csn};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      lane_q      <= lane_d;
      miso_q      <= miso_d;
      trunc_q     <= trunc_d;
      rx_sr_q     <= rx_sr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign s_axis_tready     = tready_q;
  assign spi_miso          = miso_q;
  assign interruptn        = intn_q;
  assign rx_byte           = rx_byte_q;
  assign rx_byte_valid     = rx_valid_q;
  assign stat_tx_truncated = trunc_q;
  assign frames_pending    = frames_q;
endmodule

// File: tb/tb_astropix_spi_responder_emu.sv
// Scoreboard bench: expected MISO/MOSI bytes are queued as stimulus is driven and
// compared against bytes reassembled from the DUT pins.
module tb_astropix_spi_responder_emu;
  localparam int DEPTH = 32;

  logic       clk_core = 1'b0;
  logic       clk_core_resn = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       spi_clk = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [1:0] spi_miso;
  logic       interruptn;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       stat_tx_truncated;
  logic [7:0] frames_pending;

  int checks = 0;
  int errors = 0;
  int trunc_cnt = 0;
  logic [7:0] miso_exp[$], miso_got[$], rx_exp[$], rx_got[$];
  logic [7:0] exp_b, got_b;

  astropix_spi_responder_emu #(
    .DEPTH(DEPTH), .IDLE_BYTE(8'hBC), .MOSI_MSB_FIRST(1'b0)
  ) dut (
    .clk_core(clk_core), .clk_core_resn(clk_core_resn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .interruptn(interruptn),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .stat_tx_truncated(stat_tx_truncated), .frames_pending(frames_pending)
  );

  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) begin
    #1;
    if (rx_byte_valid === 1'b1) rx_got.push_back(rx_byte);
    if (stat_tx_truncated === 1'b1) trunc_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic axis_push(input logic [7:0] data, input logic last);
    int n = 0;
    @(negedge clk_core);
    s_axis_tdata = data; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 64) begin
      @(negedge clk_core);
      n++;
    end
    if (n == 64) begin
      checks++; errors++;
      $display("FAIL axis_push_timeout tready=%b required 1", s_axis_tready);
    end
    @(negedge clk_core);
    s_axis_tvalid = 1'b0;
  endtask

  // Host model: SPI mode with idle-low clock at clk_core/8, MISO sampled before each rise.
  task automatic spi_run(input int nclk, input logic [15:0] mosi_pat);
    logic [7:0] cap = 8'h00;
    for (int i = 0; i < nclk; i++) begin
      spi_mosi = mosi_pat[i % 16];
      repeat (4) @(negedge clk_core);
      cap[2*(i%4)]   = spi_miso[0];
      cap[2*(i%4)+1] = spi_miso[1];
      spi_clk = 1'b1;
      repeat (4) @(negedge clk_core);
      spi_clk = 1'b0;
      if (i % 4 == 3) miso_got.push_back(cap);
    end
    repeat (4) @(negedge clk_core);
  endtask

  task automatic csn_set(input logic v);
    @(negedge clk_core);
    spi_csn = v;
    repeat (8) @(negedge clk_core);
  endtask

  task automatic test_reset();
    clk_core_resn = 1'b0;
    repeat (3) @(negedge clk_core);
    checks += 7;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b expected 0", s_axis_tready); end
    if (interruptn !== 1'b1) begin errors++; $display("FAIL reset_interruptn got %b expected 1", interruptn); end
    if (spi_miso !== 2'b00) begin errors++; $display("FAIL reset_miso got %b expected 00", spi_miso); end
    if (frames_pending !== 8'h00) begin errors++; $display("FAIL reset_frames got %0d expected 0", frames_pending); end
    if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h expected 00", rx_byte); end
    if (rx_byte_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b expected 0", rx_byte_valid); end
    if (stat_tx_truncated !== 1'b0) begin errors++; $display("FAIL reset_trunc got %b expected 0", stat_tx_truncated); end
    clk_core_resn = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL release_tready_early got %b expected 0", s_axis_tready); end
    @(negedge clk_core);
    checks++;
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b expected 1", s_axis_tready); end
  endtask

  task automatic test_frame();
    axis_push(8'h12, 1'b0);
    axis_push(8'h34, 1'b1);
    checks += 2;
    if (frames_pending !== 8'd1) begin errors++; $display("FAIL frame_count got %0d expected 1", frames_pending); end
    if (interruptn !== 1'b1) begin errors++; $display("FAIL frame_intn_lag got %b expected 1", interruptn); end
    @(negedge clk_core);
    checks++;
    if (interruptn !== 1'b0) begin errors++; $display("FAIL frame_intn_low got %b expected 0", interruptn); end
    miso_exp.push_back(8'h12); miso_exp.push_back(8'h34);
    miso_exp.push_back(8'hBC); miso_exp.push_back(8'hBC);
    rx_exp.push_back(8'h3C); rx_exp.push_back(8'h5A);
    csn_set(1'b0);
    spi_run(16, 16'h5A3C);
    checks += 2;
    if (interruptn !== 1'b1) begin errors++; $display("FAIL frame_intn_high got %b expected 1", interruptn); end
    if (frames_pending !== 8'd0) begin errors++; $display("FAIL frame_count_end got %0d expected 0", frames_pending); end
    csn_set(1'b1);
    checks++;
    if (trunc_cnt != 0) begin errors++; $display("FAIL frame_trunc got %0d expected 0", trunc_cnt); end
    checks++;
    if (miso_got.size() != miso_exp.size()) begin errors++; $display("FAIL frame_miso_count got %0d expected %0d", miso_got.size(), miso_exp.size()); end
    while (miso_exp.size() > 0 && miso_got.size() > 0) begin
      exp_b = miso_exp.pop_front(); got_b = miso_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL frame_miso got %h expected %h", got_b, exp_b); end
    end
    checks++;
    if (rx_got.size() != rx_exp.size()) begin errors++; $display("FAIL frame_rx_count got %0d expected %0d", rx_got.size(), rx_exp.size()); end
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      exp_b = rx_exp.pop_front(); got_b = rx_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL frame_rx got %h expected %h", got_b, exp_b); end
    end
    miso_exp.delete(); miso_got.delete(); rx_exp.delete(); rx_got.delete();
  endtask

  task automatic test_idle_and_mosi(input string name, input logic [7:0] mosi_b);
    miso_exp.push_back(8'hBC); miso_exp.push_back(8'hBC);
    rx_exp.push_back(mosi_b);
    csn_set(1'b0);
    spi_run(8, {8'h00, mosi_b});
    csn_set(1'b1);
    checks += 2;
    if (frames_pending !== 8'd0) begin errors++; $display("FAIL %s_frames got %0d expected 0", name, frames_pending); end
    if (interruptn !== 1'b1) begin errors++; $display("FAIL %s_intn got %b expected 1", name, interruptn); end
    checks++;
    if (miso_got.size() != miso_exp.size()) begin errors++; $display("FAIL %s_miso_count got %0d expected %0d", name, miso_got.size(), miso_exp.size()); end
    while (miso_exp.size() > 0 && miso_got.size() > 0) begin
      exp_b = miso_exp.pop_front(); got_b = miso_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL %s_miso got %h expected %h", name, got_b, exp_b); end
    end
    checks++;
    if (rx_got.size() != rx_exp.size()) begin errors++; $display("FAIL %s_rx_count got %0d expected %0d", name, rx_got.size(), rx_exp.size()); end
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      exp_b = rx_exp.pop_front(); got_b = rx_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL %s_rx got %h expected %h", name, got_b, exp_b); end
    end
    miso_exp.delete(); miso_got.delete(); rx_exp.delete(); rx_got.delete();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      axis_push(8'h40 + 8'(i), (i == 0) || (i == DEPTH - 1));
      miso_exp.push_back(8'h40 + 8'(i));
    end
    checks += 2;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b expected 0", s_axis_tready); end
    if (frames_pending !== 8'd2) begin errors++; $display("FAIL full_frames got %0d expected 2", frames_pending); end
    @(negedge clk_core);
    spi_csn = 1'b0;
    repeat (3) @(negedge clk_core);
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready_prepop got %b expected 0", s_axis_tready); end
    @(negedge clk_core);
    checks += 3;
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL full_tready_pop got %b expected 1", s_axis_tready); end
    if (frames_pending !== 8'd1) begin errors++; $display("FAIL full_frames_pop got %0d expected 1", frames_pending); end
    if (interruptn !== 1'b0) begin errors++; $display("FAIL full_intn got %b expected 0", interruptn); end
    repeat (4) @(negedge clk_core);
    for (int i = 0; i < 16; i++) rx_exp.push_back(8'h00);
    spi_run(4 * DEPTH, 16'h0000);
    csn_set(1'b1);
    checks += 2;
    if (frames_pending !== 8'd0) begin errors++; $display("FAIL full_frames_end got %0d expected 0", frames_pending); end
    if (interruptn !== 1'b1) begin errors++; $display("FAIL full_intn_end got %b expected 1", interruptn); end
    checks++;
    if (miso_got.size() != miso_exp.size()) begin errors++; $display("FAIL full_miso_count got %0d expected %0d", miso_got.size(), miso_exp.size()); end
    while (miso_exp.size() > 0 && miso_got.size() > 0) begin
      exp_b = miso_exp.pop_front(); got_b = miso_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL full_miso got %h expected %h", got_b, exp_b); end
    end
    checks++;
    if (rx_got.size() != rx_exp.size()) begin errors++; $display("FAIL full_rx_count got %0d expected %0d", rx_got.size(), rx_exp.size()); end
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      exp_b = rx_exp.pop_front(); got_b = rx_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL full_rx got %h expected %h", got_b, exp_b); end
    end
    miso_exp.delete(); miso_got.delete(); rx_exp.delete(); rx_got.delete();
  endtask

  // Ten tlast writes stream in while the CSN-fall load pops a tlast head in one of those cycles.
  task automatic test_back_to_back();
    axis_push(8'hA1, 1'b1);
    miso_exp.push_back(8'hA1);
    @(negedge clk_core);
    spi_csn = 1'b0;
    s_axis_tdata = 8'h5C; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    repeat (10) @(negedge clk_core);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) miso_exp.push_back(8'h5C);
    @(negedge clk_core);
    checks += 2;
    if (frames_pending !== 8'd10) begin errors++; $display("FAIL b2b_frames got %0d expected 10", frames_pending); end
    if (interruptn !== 1'b0) begin errors++; $display("FAIL b2b_intn got %b expected 0", interruptn); end
    for (int i = 0; i < 5; i++) rx_exp.push_back(8'h00);
    spi_run(44, 16'h0000);
    csn_set(1'b1);
    checks += 2;
    if (frames_pending !== 8'd0) begin errors++; $display("FAIL b2b_frames_end got %0d expected 0", frames_pending); end
    if (trunc_cnt != 0) begin errors++; $display("FAIL b2b_trunc got %0d expected 0", trunc_cnt); end
    checks++;
    if (miso_got.size() != miso_exp.size()) begin errors++; $display("FAIL b2b_miso_count got %0d expected %0d", miso_got.size(), miso_exp.size()); end
    while (miso_exp.size() > 0 && miso_got.size() > 0) begin
      exp_b = miso_exp.pop_front(); got_b = miso_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL b2b_miso got %h expected %h", got_b, exp_b); end
    end
    checks++;
    if (rx_got.size() != rx_exp.size()) begin errors++; $display("FAIL b2b_rx_count got %0d expected %0d", rx_got.size(), rx_exp.size()); end
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      exp_b = rx_exp.pop_front(); got_b = rx_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL b2b_rx got %h expected %h", got_b, exp_b); end
    end
    miso_exp.delete(); miso_got.delete(); rx_exp.delete(); rx_got.delete();
  endtask

  task automatic test_truncate();
    int t0;
    axis_push(8'h0F, 1'b1);
    t0 = trunc_cnt;
    csn_set(1'b0);
    spi_run(2, 16'hFFFF);
    csn_set(1'b1);
    checks += 3;
    if (trunc_cnt != t0 + 1) begin errors++; $display("FAIL trunc_pulses got %0d expected %0d", trunc_cnt, t0 + 1); end
    if (frames_pending !== 8'd0) begin errors++; $display("FAIL trunc_frames got %0d expected 0", frames_pending); end
    if (interruptn !== 1'b1) begin errors++; $display("FAIL trunc_intn got %b expected 1", interruptn); end
    miso_exp.push_back(8'hBC); miso_exp.push_back(8'hBC);
    rx_exp.push_back(8'h81);
    csn_set(1'b0);
    spi_run(8, 16'h0081);
    csn_set(1'b1);
    checks++;
    if (miso_got.size() != miso_exp.size()) begin errors++; $display("FAIL trunc_miso_count got %0d expected %0d", miso_got.size(), miso_exp.size()); end
    while (miso_exp.size() > 0 && miso_got.size() > 0) begin
      exp_b = miso_exp.pop_front(); got_b = miso_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL trunc_miso got %h expected %h", got_b, exp_b); end
    end
    checks++;
    if (rx_got.size() != rx_exp.size()) begin errors++; $display("FAIL trunc_rx_count got %0d expected %0d", rx_got.size(), rx_exp.size()); end
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      exp_b = rx_exp.pop_front(); got_b = rx_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL trunc_rx got %h expected %h", got_b, exp_b); end
    end
    miso_exp.delete(); miso_got.delete(); rx_exp.delete(); rx_got.delete();
  endtask

  task automatic test_reset_mid();
    axis_push(8'h99, 1'b1);
    axis_push(8'h66, 1'b0);
    csn_set(1'b0);
    spi_run(2, 16'h0000);
    checks++;
    if (spi_miso !== 2'b01) begin errors++; $display("FAIL rstmid_miso_pre got %b expected 01", spi_miso); end
    #2;
    clk_core_resn = 1'b0;
    spi_csn = 1'b1;
    #1;
    checks += 5;
    if (spi_miso !== 2'b00) begin errors++; $display("FAIL rstmid_miso got %b expected 00", spi_miso); end
    if (frames_pending !== 8'd0) begin errors++; $display("FAIL rstmid_frames got %0d expected 0", frames_pending); end
    if (interruptn !== 1'b1) begin errors++; $display("FAIL rstmid_intn got %b expected 1", interruptn); end
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rstmid_tready got %b expected 0", s_axis_tready); end
    if (stat_tx_truncated !== 1'b0) begin errors++; $display("FAIL rstmid_trunc got %b expected 0", stat_tx_truncated); end
    repeat (2) @(negedge clk_core);
    clk_core_resn = 1'b1;
    repeat (3) @(negedge clk_core);
    miso_exp.push_back(8'hBC);
    csn_set(1'b0);
    spi_run(4, 16'h0000);
    csn_set(1'b1);
    checks++;
    if (miso_got.size() != miso_exp.size()) begin errors++; $display("FAIL rstmid_miso_count got %0d expected %0d", miso_got.size(), miso_exp.size()); end
    while (miso_exp.size() > 0 && miso_got.size() > 0) begin
      exp_b = miso_exp.pop_front(); got_b = miso_got.pop_front(); checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL rstmid_miso got %h expected %h", got_b, exp_b); end
    end
    checks++;
    if (rx_got.size() != 0) begin errors++; $display("FAIL rstmid_rx_count got %0d expected 0", rx_got.size()); end
    miso_exp.delete(); miso_got.delete(); rx_exp.delete(); rx_got.delete();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_idle_and_mosi("idle", 8'hFF);
    test_idle_and_mosi("mosi", 8'hA5);
    test_full();
    test_back_to_back();
    test_truncate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/astropix_spi_responder_emu.md
ASTROPIX_SPI_RESPONDER_EMU -- requirements
Module: astropix_spi_responder_emu

Interface
REQ-001 Parameter DEPTH, default 32, frame-byte FIFO depth in bytes (power of two, 4..256).
REQ-002 Parameter IDLE_BYTE, default 8'hBC, byte shifted out when no frame data is buffered.
REQ-003 Parameter MOSI_MSB_FIRST, default 0, bit order of captured MOSI bytes.
REQ-004 clk_core  input  1  single clock for all logic.
REQ-005 clk_core_resn  input  1  reset, asynchronous, active-low.
REQ-006 s_axis_tdata  input  8  frame byte to emit.
REQ-007 s_axis_tlast  input  1  last byte of frame.
REQ-008 s_axis_tvalid  input  1  byte valid.
REQ-009 s_axis_tready  output  1  FIFO not full.
REQ-010 spi_clk  input  1  SPI clock from host; asynchronous to clk_core.
REQ-011 spi_csn  input  1  chip select from host, active-low; asynchronous.
REQ-012 spi_mosi  input  1  host data in.
REQ-013 spi_miso  output  2  dual-lane data out.
REQ-014 interruptn  output  1  low while at least one complete frame is buffered.
REQ-015 rx_byte  output  8  last captured MOSI byte.
REQ-016 rx_byte_valid  output  1  one-cycle pulse per captured MOSI byte.
REQ-017 stat_tx_truncated  output  1  one-cycle pulse when CSN deasserts mid-byte.
REQ-018 frames_pending  output  8  count of complete frames in FIFO.

Function
REQ-019 spi_clk, spi_csn, spi_mosi are each synchronized by two flops; edges are detected on the synchronized values with a third register stage.
REQ-020 Host spi_clk frequency is at most clk_core/8; at that rate no edge is missed.
REQ-021 FIFO stores 9 bits per entry (data + tlast); a write occurs on s_axis_tvalid && s_axis_tready.
REQ-022 frames_pending increments on a write with tlast=1 and decrements on a pop of an entry with tlast=1; both in one cycle leave it unchanged; it saturates at 255.
REQ-023 interruptn = (frames_pending == 0), registered, so it updates one cycle after the count changes.
REQ-024 States: IDLE (CSN high), LOAD, SHIFT.
REQ-025 IDLE -> LOAD on synchronized CSN falling edge.
REQ-026 LOAD lasts one cycle: pop FIFO head into tx shift register if FIFO non-empty, else load IDLE_BYTE; drive spi_miso = {sr[1], sr[0]}; go to SHIFT; lane count = 0.
REQ-027 SHIFT: on each synchronized spi_clk falling edge, shift sr right by 2, increment lane count; spi_miso = {sr[1], sr[0]} of the new value.
REQ-028 The 4th falling edge in a byte acts as LOAD of the next byte in the same cycle (pop or IDLE_BYTE), not as a shift; lane count returns to 0.
REQ-029 Bit order on spi_miso is LSB first: lane0 carries bits 0,2,4,6; lane1 carries bits 1,3,5,7.
REQ-030 A popped byte is never re-sent; an idle byte never consumes FIFO data.
REQ-031 MOSI: while CSN is low, sample on each synchronized spi_clk rising edge; after 8 samples, present rx_byte and pulse rx_byte_valid for one cycle; order per MOSI_MSB_FIRST.
REQ-032 A CSN rising edge in any state -> IDLE; spi_miso = 2'b00; MOSI bit counter cleared and partial MOSI bits discarded.
REQ-033 CSN rising with tx lane count != 0 pulses stat_tx_truncated; the popped byte is lost; frames_pending still reflects its tlast.
REQ-034 FIFO full: s_axis_tready = 0. FIFO empty at a LOAD point: IDLE_BYTE is sent, even in mid-frame.
REQ-035 Pointer wrap-around is modulo DEPTH; full/empty use an extra pointer bit.
REQ-036 Change of spi_miso follows the host spi_clk falling edge within 4 clk_core cycles.

Reset
REQ-037 On clk_core_resn low: FIFO empty, frames_pending=0, interruptn=1, spi_miso=2'b00, s_axis_tready=0, rx_byte=0, rx_byte_valid=0, stat_tx_truncated=0, state IDLE, synchronizers cleared to CSN=1 and CLK=0.
REQ-038 s_axis_tready rises to 1 on the first clk_core edge after reset release.
REQ-039 Reset asserted mid-transfer takes effect immediately; after release the block waits in IDLE for a fresh CSN falling edge.

Verification
REQ-040 Push frame {0x12,0x34(tlast)}; 16 SPI clocks at clk_core/8 -> MISO bytes 0x12, 0x34, 0xBC, 0xBC; interruptn low after the write and high after the 0x34 pop.
REQ-041 FIFO empty; 8 SPI clocks -> two 0xBC bytes; frames_pending stays 0; no pop.
REQ-042 MOSI 0xA5 LSB-first over 8 clocks -> one rx_byte_valid pulse with rx_byte=0xA5.
REQ-043 Push DEPTH bytes -> s_axis_tready=0; a single pop re-asserts tready next cycle; a write of tlast in the same cycle as a pop of tlast leaves frames_pending unchanged.
REQ-044 Push 0x0F (tlast); CSN rises after 2 SPI clocks -> stat_tx_truncated pulse; next transfer sends 0xBC; interruptn=1.
REQ-045 Assert clk_core_resn low during a byte -> all outputs at reset values asynchronously; after release, a new transfer sends 0xBC.
